// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: owns HI/LO and executes
// mult/multu/div/divu as fixed-latency ops plus mfhi/mflo/mthi/mtlo.
// The full result is computed at issue into shadow registers; a down
// counter provides the architectural latency, and HI/LO are updated on
// the edge where the counter returns to zero.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] E_MDU_A,
  input  logic [31:0] E_MDU_B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDU_Result
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  // Signed 32x32 -> 64 product, operands sign-extended before multiplying.
  function automatic logic [63:0] mul_s(input logic signed [31:0] a,
                                        input logic signed [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    logic signed [63:0] p;
    ea = 64'(a);
    eb = 64'(b);
    p  = ea * eb;
    return p;
  endfunction

  // Unsigned 32x32 -> 64 product.
  function automatic logic [63:0] mul_u(input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {32'd0, a};
    eb = {32'd0, b};
    return ea * eb;
  endfunction

  // Unsigned divide returning {remainder, quotient}; zero divisor yields 0
  // so the datapath never evaluates x/0 (the result is discarded anyway).
  function automatic logic [63:0] div_u(input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Signed divide via magnitudes: quotient truncates toward zero and the
  // remainder takes the dividend's sign. Working on magnitudes makes
  // 0x80000000 / -1 wrap to 0x80000000 with remainder 0 without overflow.
  function automatic logic [63:0] div_s(input logic signed [31:0] a,
                                        input logic signed [31:0] b);
    logic [31:0] ua;
    logic [31:0] ub;
    logic [63:0] qr;
    logic [31:0] q;
    logic [31:0] r;
    ua = a[31] ? (~a + 32'd1) : a;
    ub = b[31] ? (~b + 32'd1) : b;
    qr = div_u(ua, ub);
    q  = (a[31] ^ b[31]) ? (~qr[31:0] + 32'd1) : qr[31:0];
    r  = a[31] ? (~qr[63:32] + 32'd1) : qr[63:32];
    return {r, q};
  endfunction

  // Control state: the counter alone determines idle/busy.
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_commit;

  // Shadow result and architectural registers.
  logic [31:0] r_hi_t;
  logic [31:0] r_lo_t;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic             w_is_mult;
  logic             w_is_div;
  logic             w_start_ok;
  logic             w_div_zero;
  logic [CNT_W-1:0] w_load;
  logic [63:0]      w_res;
  logic             w_done;
  logic             w_mthi;
  logic             w_mtlo;

  // Decode the issuing op and compute its full 64-bit result.
  always_comb begin
    w_is_mult  = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    w_is_div   = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    w_start_ok = Start && !r_busy && (w_is_mult || w_is_div);
    w_div_zero = w_is_div && (E_MDU_B == 32'd0);
    w_load     = w_is_div ? DIV_LOAD : MULT_LOAD;
    w_mthi     = !r_busy && (MDUOp == OP_MTHI);
    w_mtlo     = !r_busy && (MDUOp == OP_MTLO);
    w_done     = r_busy && (r_cnt == CNT_ONE);
    w_res      = 64'd0;
    case (MDUOp)
      OP_MULT:  w_res = mul_s($signed(E_MDU_A), $signed(E_MDU_B));
      OP_MULTU: w_res = mul_u(E_MDU_A, E_MDU_B);
      OP_DIV:   w_res = div_s($signed(E_MDU_A), $signed(E_MDU_B));
      OP_DIVU:  w_res = div_u(E_MDU_A, E_MDU_B);
      default:  w_res = 64'd0;
    endcase
  end

  // Latency counter: load on accepted Start, count down, drop Busy at zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_commit <= 1'b0;
    end else if (w_start_ok) begin
      r_cnt    <= w_load;
      r_busy   <= 1'b1;
      r_commit <= !w_div_zero;
    end else if (r_busy) begin
      r_cnt  <= r_cnt - CNT_ONE;
      r_busy <= (r_cnt != CNT_ONE);
    end
  end

  // Shadow result captured at issue; meaningful only while r_commit is set.
  always_ff @(posedge Clk) begin
    if (w_start_ok) begin
      r_hi_t <= w_res[63:32];
      r_lo_t <= w_res[31:0];
    end
  end

  // Architectural HI: cleared on reset, written by completion or mthi.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hi <= 32'd0;
    end else if (w_done && r_commit) begin
      r_hi <= r_hi_t;
    end else if (w_mthi) begin
      r_hi <= E_MDU_A;
    end
  end

  // Architectural LO: cleared on reset, written by completion or mtlo.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_lo <= 32'd0;
    end else if (w_done && r_commit) begin
      r_lo <= r_lo_t;
    end else if (w_mtlo) begin
      r_lo <= E_MDU_A;
    end
  end

  // mfhi/mflo read path into the E/M register; zero for every other op.
  always_comb begin
    case (MDUOp)
      OP_MFHI: E_MDU_Result = r_hi;
      OP_MFLO: E_MDU_Result = r_lo;
      default: E_MDU_Result = 32'd0;
    endcase
  end

  assign Busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: latency, signed/unsigned mul/div results,
// divide by zero, move to/from HI/LO, Start during Busy and reset mid-op.
module tb_mdu;

  logic        Clk;
  logic        Reset;
  logic [31:0] E_MDU_A;
  logic [31:0] E_MDU_B;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_MDU_Result;

  int n_checks = 0;
  int n_errors = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .E_MDU_A      (E_MDU_A),
    .E_MDU_B      (E_MDU_B),
    .MDUOp        (MDUOp),
    .Start        (Start),
    .Busy         (Busy),
    .HI           (HI),
    .LO           (LO),
    .E_MDU_Result (E_MDU_Result)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns after.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue a multi-cycle op and measure how long Busy stays high; HI/LO must
  // still hold their old values in the last busy cycle.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_cycles);
    int cnt;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi  = HI;
    old_lo  = LO;
    E_MDU_A = a;
    E_MDU_B = b;
    MDUOp   = op;
    Start   = 1'b1;
    tick();
    Start   = 1'b0;
    MDUOp   = 4'd0;
    cnt     = 0;
    while (Busy === 1'b1 && cnt < 50) begin
      cnt++;
      if (cnt == exp_cycles) begin
        check({tag, " hi_held"}, HI, old_hi);
        check({tag, " lo_held"}, LO, old_lo);
      end
      tick();
    end
    check({tag, " busy_cycles"}, 32'(cnt), 32'(exp_cycles));
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] a);
    MDUOp   = op;
    E_MDU_A = a;
    tick();
    MDUOp   = 4'd0;
  endtask

  initial begin
    int cnt;
    Reset   = 1'b1;
    E_MDU_A = 32'd0;
    E_MDU_B = 32'd0;
    MDUOp   = 4'd0;
    Start   = 1'b0;
    tick();
    Reset = 1'b0;
    check("rst hi", HI, 32'd0);
    check("rst lo", LO, 32'd0);
    check("rst busy", 32'(Busy), 32'd0);
    check("rst result", E_MDU_Result, 32'd0);
    MDUOp = 4'd5;
    #1;
    check("rst mfhi", E_MDU_Result, 32'd0);
    MDUOp = 4'd0;

    run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 5);
    check("mult hi", HI, 32'hFFFFFFFF);
    check("mult lo", LO, 32'hFFFFFFFA);

    run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 5);
    check("multu hi", HI, 32'h00000002);
    check("multu lo", LO, 32'hFFFFFFFA);

    run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10);
    check("div lo", LO, 32'hFFFFFFFD);
    check("div hi", HI, 32'hFFFFFFFF);

    run_op("divu", 4'd4, 32'd7, 32'd2, 10);
    check("divu lo", LO, 32'd3);
    check("divu hi", HI, 32'd1);

    run_op("div ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10);
    check("div ovf lo", LO, 32'h80000000);
    check("div ovf hi", HI, 32'd0);

    run_op("div nn", 4'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 10);
    check("div nn lo", LO, 32'd3);
    check("div nn hi", HI, 32'hFFFFFFFF);

    run_op("div pn", 4'd3, 32'd7, 32'hFFFFFFFE, 10);
    check("div pn lo", LO, 32'hFFFFFFFD);
    check("div pn hi", HI, 32'd1);

    // Large unsigned dividend distinguishes divu from div.
    run_op("divu big", 4'd4, 32'hFFFFFFF9, 32'd2, 10);
    check("divu big lo", LO, 32'h7FFFFFFC);
    check("divu big hi", HI, 32'd1);

    move_to(4'd8, 32'h00001234);
    check("mtlo lo", LO, 32'h00001234);
    check("mtlo busy", 32'(Busy), 32'd0);
    move_to(4'd7, 32'h00000001);
    run_op("div0", 4'd3, 32'd5, 32'd0, 10);
    check("div0 lo", LO, 32'h00001234);
    check("div0 hi", HI, 32'h00000001);
    run_op("divu0", 4'd4, 32'd9, 32'd0, 10);
    check("divu0 lo", LO, 32'h00001234);

    move_to(4'd7, 32'hDEADBEEF);
    MDUOp = 4'd5;
    #1;
    check("mfhi", E_MDU_Result, 32'hDEADBEEF);
    MDUOp = 4'd6;
    #1;
    check("mflo", E_MDU_Result, 32'h00001234);
    MDUOp = 4'd7;
    #1;
    check("mthi result", E_MDU_Result, 32'd0);
    MDUOp = 4'd0;

    // Start with an op outside 1-4 does nothing.
    MDUOp = 4'd9;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    MDUOp = 4'd0;
    check("op9 busy", 32'(Busy), 32'd0);
    check("op9 hi", HI, 32'hDEADBEEF);

    // Second Start during Busy is ignored, as is mtlo while busy.
    E_MDU_A = 32'd2;
    E_MDU_B = 32'd3;
    MDUOp   = 4'd2;
    Start   = 1'b1;
    tick();
    Start   = 1'b0;
    MDUOp   = 4'd0;
    tick();
    E_MDU_A = 32'd100;
    E_MDU_B = 32'd7;
    MDUOp   = 4'd4;
    Start   = 1'b1;
    tick();
    Start   = 1'b0;
    MDUOp   = 4'd8;
    E_MDU_A = 32'h0BAD0BAD;
    tick();
    MDUOp   = 4'd0;
    cnt = 3;
    while (Busy === 1'b1 && cnt < 50) begin
      cnt++;
      tick();
    end
    check("restart busy_cycles", 32'(cnt), 32'd5);
    check("restart hi", HI, 32'd0);
    check("restart lo", LO, 32'd6);

    // Reset three cycles into a mult discards the product.
    E_MDU_A = 32'hFFFFFFFE;
    E_MDU_B = 32'd3;
    MDUOp   = 4'd1;
    Start   = 1'b1;
    tick();
    Start   = 1'b0;
    MDUOp   = 4'd0;
    tick();
    tick();
    check("pre-rst busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midrst busy", 32'(Busy), 32'd0);
    check("midrst hi", HI, 32'd0);
    check("midrst lo", LO, 32'd0);
    repeat (6) tick();
    check("midrst hi later", HI, 32'd0);
    check("midrst lo later", LO, 32'd0);

    // Start together with Reset: Reset wins.
    MDUOp = 4'd1;
    Start = 1'b1;
    Reset = 1'b1;
    tick();
    Start = 1'b0;
    Reset = 1'b0;
    MDUOp = 4'd0;
    check("rst+start busy", 32'(Busy), 32'd0);
    repeat (6) tick();
    check("rst+start lo", LO, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
